rs_issue_scheduler: RTL
=======================

// Module: rs_issue_scheduler
// PURPOSE
// - Picks ready reservation-station (RS) rows and issues them to the three functional units.
//   FU1 and FU2 are ALU units. FU3 is memory-only.
// - Sits between the RS array and the FUs; owns one registered issue slot per FU.
// - Pulses a one-hot clear back to the RS when a row is handed off.
// - Round-robin fairness: one pointer for the ALU class, one for the memory class.
// PARAMETERS
// - RS_ROWS  16  number of RS rows; power of 2, >= 4
// - ROW_W    4   $clog2(RS_ROWS), index width
// PORTS
// - clk          in   1            rising-edge clock
// - rst_n        in   1            asynchronous active-low reset
// - flush        in   1            synchronous pipeline flush
// - rs_in_use    in   RS_ROWS      per-row rs_row_struct.in_use
// - rs_ready     in   RS_ROWS      per-row Src0Ready & Src1Ready
// - rs_is_mem    in   RS_ROWS      per-row MemRead | MemWrite
// - fu_ready     in   3            FU accepts an issue this cycle; [0]=FU1, [1]=FU2, [2]=FU3
// - issue_valid  out  3            slot holds a row for that FU
// - issue_row    out  3*ROW_W      row index per slot; slot k at [k*ROW_W +: ROW_W]
// - issue_clear  out  RS_ROWS      one-hot-per-fire; RS frees these rows at the next edge
// BEHAVIOUR
// - Reset (async, rst_n=0): issue_valid=0, issue_row=0, alu_ptr=0, mem_ptr=0, stat counters=0.
//   issue_clear=0 while in reset.
// - Fire:
//   - fire[k] = issue_valid[k] & fu_ready[k] & ~flush.
//   - issue_clear[row_k] = 1 in the same cycle, combinationally.
//   - Two slots never hold the same row, so issue_clear has up to 3 bits set.
// - Slot hold: while issue_valid[k] & ~fu_ready[k], issue_row[k] is held stable.
// - Slot free: slot k is free when ~issue_valid[k] | fire[k].
//   A free slot is reloaded at the next edge, giving 1 issue/cycle/FU back-to-back.
// - Candidate: rs_in_use & rs_ready & ~held.
//   - held = rows currently in any valid slot, including rows firing this cycle.
//   - This prevents re-pick before the RS drops in_use.
// - ALU arbitration:
//   - Candidates with rs_is_mem=0 only.
//   - Scan circularly from alu_ptr; first hit goes to the lowest-numbered free ALU slot (FU1 before FU2).
//   - Second hit goes to the other free ALU slot, if any.
// - MEM arbitration: candidates with rs_is_mem=1, scanned from mem_ptr, go to FU3 when its slot is free.
// - Latency: candidate at cycle t appears on issue_valid/issue_row at t+1.
// - Pointers:
//   - After a grant, the pointer moves to (last granted row + 1) mod RS_ROWS.
//   - Wrap 15 -> 0 is required.
//   - No grant leaves the pointer unchanged.
// - Flush:
//   - Flush takes priority over fire and load.
//   - issue_clear=0 that cycle, no fire.
//   - All slots become invalid at the next edge; pointers reset to 0.
// - Mid-operation reset: slots are dropped immediately (async); no issue_clear is emitted.
// - No candidates: slots stay/become invalid; issue_row holds its last value (don't-care when invalid).
// CONFIGURATION
// - Macro ISSUE_STATS_EN.
// - Defined:
//   - Adds outputs stat_issued[31:0] (total fires, +0..3 per cycle) and stat_stall[31:0].
//   - stat_stall = cycles with any issue_valid & ~fu_ready.
//   - Both saturate at 32'hFFFF_FFFF.
//   - Both cleared by reset only, not by flush.
// - Undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
// - Reset: rst_n=0 with rs_ready all 1 -> issue_valid=000 and issue_clear=0 throughout.
//   Deassert -> first issue one cycle later.
// - ALU pair: rows 2,5 ALU-ready, fu_ready=111.
//   -> cycle+1: FU1=2, FU2=5; issue_clear=0x0024 that cycle; alu_ptr=6.
// - Mem stall:
//   - Setup: row 7 mem-ready, fu_ready[2]=0 for 3 cycles.
//   - Required: issue_row[FU3]=7 held, no issue_clear.
//   - Then fu_ready[2]=1 -> issue_clear=0x0080 for one cycle.
// - Wrap/fairness:
//   - Setup: alu_ptr=14; ALU-ready rows 1 and 15; only FU1 free.
//   - Required: FU1 gets 15, then 1 next cycle; alu_ptr=0 then 2.
// - Flush:
//   - Setup: all three slots valid, fu_ready=111 together with flush=1.
//   - Required: issue_clear=0; next cycle issue_valid=000 and both pointers=0.
// - ISSUE_STATS_EN: 10 cycles of 3 fires plus 4 stall cycles -> stat_issued=30, stat_stall=4.

Source files
------------

// File: rtl/rs_issue_scheduler_if.sv
// RS-array and functional-unit side of the issue scheduler.
// master = scheduler, slave = RS array / FU environment.
interface rs_issue_scheduler_if #(
    parameter int RS_ROWS = 16,
    parameter int ROW_W   = $clog2(RS_ROWS)
);
    logic [RS_ROWS-1:0] rs_in_use;
    logic [RS_ROWS-1:0] rs_ready;
    logic [RS_ROWS-1:0] rs_is_mem;
    logic [2:0]         fu_ready;
    logic [2:0]         issue_valid;
    logic [3*ROW_W-1:0] issue_row;
    logic [RS_ROWS-1:0] issue_clear;

    modport master (
        input  rs_in_use, rs_ready, rs_is_mem, fu_ready,
        output issue_valid, issue_row, issue_clear
    );

    modport slave (
        output rs_in_use, rs_ready, rs_is_mem, fu_ready,
        input  issue_valid, issue_row, issue_clear
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Issues ready RS rows to FU1/FU2 (ALU) and FU3 (memory) with round-robin fairness per class.
// Define ISSUE_STATS_EN to add the stat_issued / stat_stall counters.
module rs_issue_scheduler #(
    parameter int RS_ROWS = 16,
    parameter int ROW_W   = $clog2(RS_ROWS)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    rs_issue_scheduler_if.master bus
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    logic [2:0]         slot_valid;
    logic [ROW_W-1:0]   slot_row [3];
    logic [ROW_W-1:0]   alu_ptr;
    logic [ROW_W-1:0]   mem_ptr;

    logic [2:0]         fire;
    logic [2:0]         slot_free;
    logic [RS_ROWS-1:0] held;
    logic [RS_ROWS-1:0] clear;
    logic [RS_ROWS-1:0] alu_cand;
    logic [RS_ROWS-1:0] mem_cand;

    logic               alu_hit1, alu_hit2, mem_hit;
    logic [ROW_W-1:0]   alu_row1, alu_row2, mem_row;
    logic [ROW_W-1:0]   alu_idx, mem_idx;

    logic [2:0]         grant;
    logic [ROW_W-1:0]   grant_row [3];
    logic               alu_adv;
    logic [ROW_W-1:0]   alu_last;

    // Rows sitting in any valid slot are held, even when firing, because the RS
    // only drops in_use at the next edge.
    always_comb begin
        fire      = slot_valid & bus.fu_ready & {3{~flush}};
        slot_free = ~slot_valid | fire;
        held      = '0;
        clear     = '0;
        for (int k = 0; k < 3; k++) begin
            if (slot_valid[k]) held[slot_row[k]]  = 1'b1;
            if (fire[k])       clear[slot_row[k]] = 1'b1;
        end
        alu_cand = bus.rs_in_use & bus.rs_ready & ~held & ~bus.rs_is_mem;
        mem_cand = bus.rs_in_use & bus.rs_ready & ~held &  bus.rs_is_mem;
    end

    always_comb begin
        alu_hit1 = 1'b0;
        alu_hit2 = 1'b0;
        alu_row1 = '0;
        alu_row2 = '0;
        mem_hit  = 1'b0;
        mem_row  = '0;
        alu_idx  = '0;
        mem_idx  = '0;
        for (int i = 0; i < RS_ROWS; i++) begin
            alu_idx = alu_ptr + ROW_W'(i);
            if (alu_cand[alu_idx]) begin
                if (!alu_hit1) begin
                    alu_hit1 = 1'b1;
                    alu_row1 = alu_idx;
                end else if (!alu_hit2) begin
                    alu_hit2 = 1'b1;
                    alu_row2 = alu_idx;
                end
            end
            mem_idx = mem_ptr + ROW_W'(i);
            if (mem_cand[mem_idx] && !mem_hit) begin
                mem_hit = 1'b1;
                mem_row = mem_idx;
            end
        end
    end

    // First ALU hit goes to the lowest free ALU slot; second hit only if both are free.
    always_comb begin
        grant = '0;
        for (int k = 0; k < 3; k++) grant_row[k] = '0;
        if (slot_free[0]) begin
            grant[0]     = alu_hit1;
            grant_row[0] = alu_row1;
            if (slot_free[1]) begin
                grant[1]     = alu_hit2;
                grant_row[1] = alu_row2;
            end
        end else if (slot_free[1]) begin
            grant[1]     = alu_hit1;
            grant_row[1] = alu_row1;
        end
        grant[2]     = slot_free[2] & mem_hit;
        grant_row[2] = mem_row;
        alu_adv  = grant[0] | grant[1];
        alu_last = (grant[0] && grant[1]) ? alu_row2 : alu_row1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int k = 0; k < 3; k++) slot_row[k] <= '0;
            alu_ptr <= '0;
            mem_ptr <= '0;
        end else if (flush) begin
            slot_valid <= '0;
            alu_ptr    <= '0;
            mem_ptr    <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (slot_free[k]) begin
                    slot_valid[k] <= grant[k];
                    if (grant[k]) slot_row[k] <= grant_row[k];
                end
            end
            if (alu_adv)  alu_ptr <= alu_last + ROW_W'(1);
            if (grant[2]) mem_ptr <= mem_row + ROW_W'(1);
        end
    end

    assign bus.issue_valid = slot_valid;
    assign bus.issue_row   = {slot_row[2], slot_row[1], slot_row[0]};
    assign bus.issue_clear = clear;

`ifdef ISSUE_STATS_EN
    logic [1:0]  fire_cnt;
    logic [32:0] issued_sum;

    assign fire_cnt   = 2'(fire[0]) + 2'(fire[1]) + 2'(fire[2]);
    assign issued_sum = {1'b0, stat_issued} + 33'(fire_cnt);

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            stat_issued <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
            if ((|(slot_valid & ~bus.fu_ready)) && (stat_stall != 32'hFFFF_FFFF))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
